ika9958_syncrx: RTL

- External composite-sync receiver for the IKA9958 screen timing generator.
- It is the receiving counterpart of that generator, which accepts an external horizontal reset (active low) to align its horizontal counter.
- This block takes a raw external composite sync, filters it, measures line period and pulse width, and locks a flywheel to the incoming line rate.
- It emits clean one-dot horizontal and vertical reset strobes that drive the generator's external reset inputs.

---
 rtl/ika9958_syncrx.sv | 102 ++++++++++
 1 files changed

// File: rtl/ika9958_syncrx.sv
// ika9958_syncrx: composite sync receiver with line flywheel; IKA9958_SYNCRX_STATUS_EN adds status outputs
module ika9958_syncrx #(
  parameter int LINE_LEN  = 341,
  parameter int TOL       = 2,
  parameter int FILT_LEN  = 4,
  parameter int LOCK_CNT  = 4,
  parameter int MISS_MAX  = 8,
  parameter int BROAD_MIN = 80
) (
  input  logic       i_phiA,
  input  logic       i_RST,
  input  logic       i_phiL_NCEN,
  input  logic       i_EXTSYNC_EN,
  input  logic       i_CSYNC_n,
  output logic       o_HRST_n,
  output logic       o_VRST_n,
  output logic       o_LOCK
`ifdef IKA9958_SYNCRX_STATUS_EN
  ,
  output logic [9:0] o_LINE_PERIOD,
  output logic [3:0] o_MISS_CNT
`endif
);
  localparam int FW = $clog2(FILT_LEN + 1);
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
  state_t state;
  logic sync1, sync2, pend, accept, rise, in_win, fly, broad_hit;
  logic [FW-1:0] filt;
  logic [7:0] wid;
  logic [1:0] broad, broad_inc;
  logic [9:0] per, p;
  logic [2:0] good;
  logic [3:0] miss;
  always_comb begin
    accept = !sync2 && (filt == FW'(FILT_LEN - 1));
    rise = sync2 && (wid != 8'd0);
    p = &per ? per : per + 10'd1;
    in_win = (p >= 10'(LINE_LEN - TOL)) && (p <= 10'(LINE_LEN + TOL));
    fly = p == 10'(LINE_LEN + TOL + 1);
    broad_inc = &broad ? broad : broad + 2'd1;
    broad_hit = (wid >= 8'(BROAD_MIN)) && (&broad_inc) && (state == LOCKED) && i_EXTSYNC_EN;
  end
  assign o_LOCK = state == LOCKED;
  always_ff @(posedge i_phiA)
    if (i_RST) begin
      state <= UNLOCKED;
      {sync1, sync2, o_HRST_n, o_VRST_n} <= '1;
      filt <= '0;
      wid <= '0;
      pend <= 1'b0;
      broad <= '0;
      per <= '0;
      good <= '0;
      miss <= '0;
    end else if (i_phiL_NCEN) begin
      sync1 <= i_CSYNC_n;
      sync2 <= sync1;
      filt <= sync2 ? '0 : (filt == FW'(FILT_LEN)) ? filt : filt + FW'(1);
      wid <= sync2 ? '0 : &wid ? wid : wid + 8'd1;
      pend <= accept | (pend & ~rise);
      broad <= !(rise && pend) ? broad : ((wid < 8'(BROAD_MIN)) || broad_hit) ? 2'd0 : broad_inc;
      o_VRST_n <= !(rise && pend && broad_hit);
      o_HRST_n <= 1'b1;
      per <= accept ? '0 : p;
      if (!i_EXTSYNC_EN) begin
        state <= UNLOCKED;
        good <= '0;
        miss <= '0;
      end else case (state)
        UNLOCKED:
          if (accept) begin
            state <= ACQUIRE;
            good <= '0;
          end
        ACQUIRE:
          if (accept) begin
            good <= in_win ? good + 3'd1 : '0;
            if (in_win && (good == 3'(LOCK_CNT - 1))) begin
              state <= LOCKED;
              miss <= '0;
            end
          end else if (&p) state <= UNLOCKED;
        LOCKED:
          if (accept && in_win) begin
            o_HRST_n <= 1'b0;
            miss <= '0;
          end else begin
            per <= fly ? 10'(TOL + 1) : p;
            o_HRST_n <= !fly;
            if (fly) miss <= miss + 4'd1;
            if (fly && (miss == 4'(MISS_MAX - 1))) state <= UNLOCKED;
          end
        default: state <= UNLOCKED;
      endcase
    end
`ifdef IKA9958_SYNCRX_STATUS_EN
  always_ff @(posedge i_phiA)
    if (i_RST) o_LINE_PERIOD <= '0;
    else if (i_phiL_NCEN && accept) o_LINE_PERIOD <= p;
  assign o_MISS_CNT = miss;
`endif
endmodule
